alu_scheduler: RTL

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_scheduler_pkg.sv | 46 ++++
 rtl/alu_scheduler_alu.sv | 73 +++++++
 rtl/alu_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_scheduler_pkg.sv
// Shared ALU op codes, status-register bit positions and the per-op flag-write mask table
// used by the scheduler and its registered ALU.
package alu_scheduler_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 5;
  localparam int FLAG_W = 7;

  localparam logic [OP_W-1:0] OP_ASL  = 5'd0;
  localparam logic [OP_W-1:0] OP_LSR  = 5'd1;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd2;
  localparam logic [OP_W-1:0] OP_ROR  = 5'd3;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd4;
  localparam logic [OP_W-1:0] OP_CMP  = 5'd5;
  localparam logic [OP_W-1:0] OP_AND  = 5'd6;
  localparam logic [OP_W-1:0] OP_OR   = 5'd7;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd8;
  localparam logic [OP_W-1:0] OP_INC  = 5'd9;
  localparam logic [OP_W-1:0] OP_DEC  = 5'd10;
  localparam logic [OP_W-1:0] OP_FLG  = 5'd11;
  localparam logic [OP_W-1:0] OP_NONE = 5'h1F;

  // Status register bit positions; bits 3..6 hold flags this ALU never produces.
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  localparam logic [FLAG_W-1:0] MASK_CZN = (7'd1 << FLAG_C) | (7'd1 << FLAG_Z) | (7'd1 << FLAG_N);
  localparam logic [FLAG_W-1:0] MASK_ZN  = (7'd1 << FLAG_Z) | (7'd1 << FLAG_N);

  typedef enum logic {
    TAG_EXE = 1'b0,
    TAG_AGU = 1'b1
  } req_tag_e;

  function automatic logic [FLAG_W-1:0] flagMask(input logic [OP_W-1:0] op);
    logic [FLAG_W-1:0] m;
    case (op)
      OP_ASL, OP_LSR, OP_ROL, OP_ROR, OP_ADD, OP_CMP: m = MASK_CZN;
      OP_AND, OP_OR, OP_XOR, OP_INC, OP_DEC, OP_FLG:  m = MASK_ZN;
      default:                                        m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_scheduler_alu.sv
// Registered 8-bit ALU: result and raw flags appear one cycle after op/operands are presented.
// Flags not produced by an op pass through from the incoming status.
module alu_scheduler_alu
  import alu_scheduler_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [FLAG_W-1:0] i_status_flags_in,
  output logic [DATA_W-1:0] o_result,
  output logic [FLAG_W-1:0] o_flags
);

  logic [DATA_W-1:0] w_result;
  logic [FLAG_W-1:0] w_flags;
  logic [DATA_W:0]   w_sum;
  logic              w_carry;
  logic              w_cin;
  logic [DATA_W-1:0] r_result;
  logic [FLAG_W-1:0] r_flags;

  assign w_cin = i_status_flags_in[FLAG_C];

  always_comb begin
    w_result = '0;
    w_carry  = w_cin;
    w_sum    = '0;
    case (i_op)
      OP_ASL: begin w_result = {i_a[6:0], 1'b0};  w_carry = i_a[7]; end
      OP_LSR: begin w_result = {1'b0, i_a[7:1]};  w_carry = i_a[0]; end
      OP_ROL: begin w_result = {i_a[6:0], w_cin}; w_carry = i_a[7]; end
      OP_ROR: begin w_result = {w_cin, i_a[7:1]}; w_carry = i_a[0]; end
      OP_ADD: begin
        w_sum    = {1'b0, i_a} + {1'b0, i_b} + {8'd0, w_cin};
        w_result = w_sum[7:0];
        w_carry  = w_sum[8];
      end
      // Carry set means no borrow, i.e. A >= B unsigned.
      OP_CMP: begin
        w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + 9'd1;
        w_result = w_sum[7:0];
        w_carry  = w_sum[8];
      end
      OP_AND: w_result = i_a & i_b;
      OP_OR:  w_result = i_a | i_b;
      OP_XOR: w_result = i_a ^ i_b;
      OP_INC: w_result = i_a + 8'd1;
      OP_DEC: w_result = i_a - 8'd1;
      OP_FLG: w_result = i_a;
      default: w_result = '0;
    endcase
    w_flags         = i_status_flags_in;
    w_flags[FLAG_C] = w_carry;
    w_flags[FLAG_Z] = (w_result == '0);
    w_flags[FLAG_N] = w_result[7];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_result <= w_result;
      r_flags  <= w_flags;
    end
  end

  assign o_result = r_result;
  assign o_flags  = r_flags;

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one registered ALU between the EXE and AGU requesters,
// with a one-bit in-flight tag, per-op status masking, flush and status forwarding.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter bit RR_RESET_EXE = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_exe_req,
  input  logic [OP_W-1:0]   i_exe_op,
  input  logic [DATA_W-1:0] i_exe_a,
  input  logic [DATA_W-1:0] i_exe_b,
  input  logic              i_agu_req,
  input  logic [OP_W-1:0]   i_agu_op,
  input  logic [DATA_W-1:0] i_agu_a,
  input  logic [DATA_W-1:0] i_agu_b,
  input  logic              i_flush,
  input  logic [FLAG_W-1:0] i_status_in,
  output logic              o_exe_gnt,
  output logic              o_agu_gnt,
  output logic              o_exe_valid,
  output logic              o_agu_valid,
  output logic [DATA_W-1:0] o_exe_result,
  output logic [DATA_W-1:0] o_agu_result,
  output logic [FLAG_W-1:0] o_exe_flags,
  output logic [FLAG_W-1:0] o_status_out,
  output logic              o_status_we
);

  logic              w_exeGnt;
  logic              w_aguGnt;
  logic              w_anyGnt;
  logic [OP_W-1:0]   w_aluOp;
  logic [DATA_W-1:0] w_aluA;
  logic [DATA_W-1:0] w_aluB;
  logic [DATA_W-1:0] w_aluResult;
  logic [FLAG_W-1:0] w_aluFlags;
  logic [FLAG_W-1:0] w_statusOut;
  logic              w_exeValid;
  logic              w_aguValid;
  logic              w_statusWe;

  logic              r_prefExe;
  logic              r_valid;
  req_tag_e          r_tag;
  logic [FLAG_W-1:0] r_mask;

  // Grants are suppressed while reset is held so nothing issues into a clearing pipeline.
  assign w_exeGnt = i_rst_n & i_exe_req & (~i_agu_req | r_prefExe);
  assign w_aguGnt = i_rst_n & i_agu_req & ~w_exeGnt;
  assign w_anyGnt = w_exeGnt | w_aguGnt;

  always_comb begin
    w_aluOp = OP_NONE;
    w_aluA  = '0;
    w_aluB  = '0;
    if (w_exeGnt) begin
      w_aluOp = i_exe_op;
      w_aluA  = i_exe_a;
      w_aluB  = i_exe_b;
    end else if (w_aguGnt) begin
      w_aluOp = i_agu_op;
      w_aluA  = i_agu_a;
      w_aluB  = i_agu_b;
    end
  end

  // The mask is latched at issue so AGU ops always carry an empty mask.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_prefExe <= RR_RESET_EXE;
      r_tag     <= TAG_EXE;
      r_mask    <= '0;
    end else begin
      r_valid <= w_anyGnt;
      if (w_anyGnt) begin
        r_prefExe <= w_aguGnt;
        r_tag     <= w_aguGnt ? TAG_AGU : TAG_EXE;
        r_mask    <= w_exeGnt ? flagMask(i_exe_op) : '0;
      end
    end
  end

  assign w_exeValid  = i_rst_n & r_valid & (r_tag == TAG_EXE) & ~i_flush;
  assign w_aguValid  = i_rst_n & r_valid & (r_tag == TAG_AGU);
  assign w_statusWe  = w_exeValid & (|r_mask);
  assign w_statusOut = w_statusWe ? ((i_status_in & ~r_mask) | (w_aluFlags & r_mask)) : i_status_in;

  // The op issued alongside a status write sees the freshly merged flags.
  alu_scheduler_alu u_alu (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_op              (w_aluOp),
    .i_a               (w_aluA),
    .i_b               (w_aluB),
    .i_status_flags_in (w_statusOut),
    .o_result          (w_aluResult),
    .o_flags           (w_aluFlags)
  );

  assign o_exe_gnt    = w_exeGnt;
  assign o_agu_gnt    = w_aguGnt;
  assign o_exe_valid  = w_exeValid;
  assign o_agu_valid  = w_aguValid;
  assign o_exe_result = w_exeValid ? w_aluResult : '0;
  assign o_agu_result = w_aguValid ? w_aluResult : '0;
  assign o_exe_flags  = w_exeValid ? w_aluFlags : '0;
  assign o_status_we  = w_statusWe;
  assign o_status_out = w_statusOut;

endmodule
